// File: rtl/mux8way_rr_arb.sv
// 8-way round-robin merging mux with a registered valid/ready output stage.
// Define MUX8WAY_LOCK_EN to add last_i and lock the grant to one source until its end-of-packet word.
module mux8way_rr_arb #(
   parameter int WIDTH = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [8*WIDTH-1:0] in_i,
   input  logic [7:0]         valid_i,
   output logic [7:0]         ready_o,
   output logic [WIDTH-1:0]   out_o,
   output logic [2:0]         sel_o,
   output logic               valid_o,
`ifdef MUX8WAY_LOCK_EN
   input  logic [7:0]         last_i,
`endif
   input  logic               ready_i
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]       state;
   logic [2:0]       ptr;
   logic             can_load;
   logic             grant_found;
   logic [2:0]       grant_idx;
   logic [2:0]       cand;
   logic             accept;
   logic [WIDTH-1:0] words [8];

`ifdef MUX8WAY_LOCK_EN
   logic             locked;
   logic [2:0]       lock_src;
`endif

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         words[k] = in_i[k*WIDTH +: WIDTH];
      end
   end

   assign valid_o  = (state == ST_FULL);
   assign can_load = (state == ST_EMPTY) || ready_i;

   // First valid source at or after ptr, wrapping; a held lock overrides the search.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = ptr;
      cand        = ptr;
      for (int i = 0; i < 8; i++) begin
         cand = ptr + 3'(i);
         if (!grant_found && valid_i[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
`ifdef MUX8WAY_LOCK_EN
      if (locked) begin
         grant_found = valid_i[lock_src];
         grant_idx   = lock_src;
      end
`endif
   end

   assign accept = can_load && grant_found;

   always_comb begin
      ready_o = 8'h00;
      if (!rst_i && accept) begin
         ready_o[grant_idx] = 1'b1;
      end
   end

   // Drain and refill share one edge, so a held-ready consumer sees no bubble.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_EMPTY;
         out_o <= '0;
         sel_o <= 3'd0;
      end else if (accept) begin
         state <= ST_FULL;
         out_o <= words[grant_idx];
         sel_o <= grant_idx;
      end else if ((state == ST_FULL) && ready_i) begin
         state <= ST_EMPTY;
      end
   end

`ifdef MUX8WAY_LOCK_EN
   // The pointer only moves when a packet ends, so a locked source cannot reorder the rotation.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr      <= 3'd0;
         locked   <= 1'b0;
         lock_src <= 3'd0;
      end else if (accept) begin
         locked   <= !last_i[grant_idx];
         lock_src <= grant_idx;
         if (last_i[grant_idx]) begin
            ptr <= grant_idx + 3'd1;
         end
      end
   end
`else
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr <= 3'd0;
      end else if (accept) begin
         ptr <= grant_idx + 3'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mux8way_rr_arb.sv
// Scoreboard bench for mux8way_rr_arb; the lock sequence runs only when MUX8WAY_LOCK_EN is defined.
module tb_mux8way_rr_arb;

   localparam int WIDTH = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic [8*WIDTH-1:0] in_bus;
   logic [7:0]         valid;
   logic [7:0]         ready;
   logic [WIDTH-1:0]   out;
   logic [2:0]         sel;
   logic               valid_out;
   logic               ready_in;
`ifdef MUX8WAY_LOCK_EN
   logic [7:0]         last;
`endif

   int checks = 0;
   int errors = 0;
   logic [18:0] exp_q[$];

   mux8way_rr_arb #(.WIDTH(WIDTH)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .in_i    (in_bus),
      .valid_i (valid),
      .ready_o (ready),
      .out_o   (out),
      .sel_o   (sel),
      .valid_o (valid_out),
`ifdef MUX8WAY_LOCK_EN
      .last_i  (last),
`endif
      .ready_i (ready_in)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] v, input logic r);
      valid    = v;
      ready_in = r;
   endtask

   task automatic set_word(input int k, input logic [15:0] w);
      in_bus[k*WIDTH +: WIDTH] = w;
   endtask

   task automatic set_words(input logic [15:0] base);
      for (int k = 0; k < 8; k++) set_word(k, base + 16'(k));
   endtask

   task automatic push_exp(input logic [2:0] s, input logic [15:0] w);
      exp_q.push_back({s, w});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every word leaving the output stage must match the head of the scoreboard.
   initial begin
      logic [18:0] exp_item;
      forever begin
         @(negedge clk);
         if (!rst && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_word: got sel=%0d out=%0h, expected none", sel, out);
            end else begin
               exp_item = exp_q.pop_front();
               check_output("out_word", 32'({sel, out}), 32'(exp_item));
            end
         end
      end
   end

   initial begin
      rst    = 1'b1;
      in_bus = '0;
`ifdef MUX8WAY_LOCK_EN
      last   = 8'hFF;
`endif
      apply_stimulus(8'hFF, 1'b0);
      #2;
      check_output("reset_ready", 32'(ready), 32'h00);
      check_output("reset_valid", 32'(valid_out), 32'h0);
      step();
      step();
      apply_stimulus(8'h00, 1'b1);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         check_output("idle_valid", 32'(valid_out), 32'h0);
         check_output("idle_ready", 32'(ready), 32'h00);
         check_output("idle_out", 32'(out), 32'h0);
         check_output("idle_sel", 32'(sel), 32'h0);
         step();
      end

      set_word(3, 16'h1234);
      apply_stimulus(8'h08, 1'b1);
      #1;
      check_output("single_ready", 32'(ready), 32'h08);
      push_exp(3'd3, 16'h1234);
      step();
      check_output("single_valid", 32'(valid_out), 32'h1);
      check_output("single_sel", 32'(sel), 32'h3);
      check_output("single_out", 32'(out), 32'h1234);

      set_word(7, 16'h7777);
      apply_stimulus(8'h80, 1'b1);
      #1;
      check_output("wrap_ready", 32'(ready), 32'h80);
      push_exp(3'd7, 16'h7777);
      step();

      set_words(16'h0000);
      apply_stimulus(8'hFF, 1'b1);
      for (int i = 0; i < 16; i++) push_exp(3'(i % 8), 16'(i % 8));
      #1;
      check_output("rr_first_ready", 32'(ready), 32'h01);
      for (int i = 0; i < 16; i++) begin
         step();
         check_output("rr_no_bubble", 32'(valid_out), 32'h1);
         check_output("rr_sel", 32'(sel), 32'(i % 8));
      end
      apply_stimulus(8'h00, 1'b1);
      step();
      check_output("drain_empty", 32'(valid_out), 32'h0);
      check_output("drain_out_kept", 32'(out), 32'h0007);

      set_word(2, 16'h0022);
      apply_stimulus(8'h04, 1'b1);
      push_exp(3'd2, 16'h0022);
      step();
      set_words(16'h00A0);
      apply_stimulus(8'hFF, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check_output("bp_ready", 32'(ready), 32'h00);
         check_output("bp_valid", 32'(valid_out), 32'h1);
         check_output("bp_sel", 32'(sel), 32'h2);
         check_output("bp_out", 32'(out), 32'h0022);
         step();
      end
      apply_stimulus(8'hFF, 1'b1);
      #1;
      check_output("bp_release_ready", 32'(ready), 32'h08);
      push_exp(3'd3, 16'h00A3);
      step();
      check_output("bp_release_sel", 32'(sel), 32'h3);

      apply_stimulus(8'h10, 1'b1);
      step();
      apply_stimulus(8'hFF, 1'b0);
      #1;
      check_output("pre_rst_sel", 32'(sel), 32'h4);
      rst = 1'b1;
      #1;
      check_output("mid_rst_valid", 32'(valid_out), 32'h0);
      check_output("mid_rst_ready", 32'(ready), 32'h00);
      check_output("mid_rst_out", 32'(out), 32'h0);
      step();
      step();
      rst = 1'b0;
      set_words(16'h0000);
      apply_stimulus(8'hFF, 1'b1);
      #1;
      check_output("post_rst_ready", 32'(ready), 32'h01);
      push_exp(3'd0, 16'h0000);
      step();
      check_output("post_rst_sel", 32'(sel), 32'h0);

`ifdef MUX8WAY_LOCK_EN
      set_word(0, 16'h0B00);
      set_word(1, 16'h0B01);
      last = 8'h00;
      apply_stimulus(8'h03, 1'b1);
      #1;
      check_output("lock_ready_w0", 32'(ready), 32'h02);
      push_exp(3'd1, 16'h0B01);
      step();
      set_word(1, 16'h0B11);
      #1;
      check_output("lock_ready_w1", 32'(ready), 32'h02);
      push_exp(3'd1, 16'h0B11);
      step();
      set_word(1, 16'h0B21);
      last = 8'h02;
      #1;
      check_output("lock_ready_w2", 32'(ready), 32'h02);
      push_exp(3'd1, 16'h0B21);
      step();
      apply_stimulus(8'h01, 1'b1);
      #1;
      check_output("lock_release_ready", 32'(ready), 32'h01);
      push_exp(3'd0, 16'h0B00);
      step();
`endif

      apply_stimulus(8'h00, 1'b1);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      check_output("queue_drained", 32'(exp_q.size()), 32'h0);
      step();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
